alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one ALU instance between NUM_REQ requesters, e.g. the execute stage and the branch-compare unit.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Round-robin grant; operands go through the ALU combinationally; result and isTrue are registered and held until the owner accepts.

Parameters:
- DATAWIDTH, 32, operand/result width; passed to the ALU.
- NUM_REQ, 2, number of requesters; legal range 2..8.
- IDW, $clog2(NUM_REQ), width of the owner/pointer index.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester grant; one-hot or zero.
- req_a  input  NUM_REQ x DATAWIDTH  operand A per requester (packed 2-D).
- req_b  input  NUM_REQ x DATAWIDTH  operand B per requester.
- req_op  input  NUM_REQ x 4  ALUControl code per requester.
- rsp_valid  output  NUM_REQ  result valid; one-hot or zero; set only for the owner.
- rsp_ready  input  NUM_REQ  per-requester response accept.
- rsp_result  output  DATAWIDTH  registered ALU Result, shared by all requesters.
- rsp_is_true  output  1  registered ALU isTrue, shared by all requesters.
- busy  output  1  high while a response is held (state RESP).

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr_ptr=0, owner=0.
  - rsp_valid=0, rsp_result=0, rsp_is_true=0, busy=0.
  - req_ready=0 while rst_n low.
- States:
  - IDLE: no result held.
  - RESP: result held for owner.
- Accept slot: open when state==IDLE, or state==RESP && rsp_ready[owner].
- Arbitration:
  - Only while the slot is open.
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - First set bit g gets req_ready[g]=1, combinationally in the same cycle.
  - All other req_ready bits are 0.
- Handshake:
  - A request transfers when req_valid[g] && req_ready[g].
  - The ALU is fed req_a[g], req_b[g], req_op[g] in that cycle.
  - On the next edge: rsp_result and rsp_is_true load, owner=g, rr_ptr=(g+1) mod NUM_REQ, state=RESP.
- Latency: request transfer at cycle N gives rsp_valid[g]=1 at cycle N+1.
- Throughput: one op per cycle when the owner holds rsp_ready high (back-to-back in RESP).
- RESP without rsp_ready[owner]:
  - rsp_valid, rsp_result and rsp_is_true hold stable.
  - req_ready=0; rr_ptr unchanged.
- RESP with rsp_ready[owner] and no req_valid: next state IDLE, rsp_valid=0. rsp_result keeps its last value (don't-care).
- rsp_ready from non-owners is ignored.
- req_valid dropped before grant: legal, nothing happens.
- Requester contract: once req_valid is raised, a-operand, b-operand and op stay stable until granted. A bench assertion checks this.
- Unknown op codes (>4'b1011): ALU returns 0, so result=0 and is_true=0. No error is flagged.
- Reset mid-RESP: the held result is discarded; no response is delivered.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined:
  - Fixed priority; the lowest index wins.
  - rr_ptr is removed and the search always starts at 0.
  - Starvation of high indices is accepted (branch unit at index 0).
- Undefined: round-robin exactly as in Behaviour.

Decomposition:
- Package alu_pkg:
  - typedef enum logic [3:0] alu_op_t: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, EQ=8, NE=9, LT=10, GE=11.
  - typedef enum logic arb_state_t: IDLE, RESP.
  - Constant ALU_OP_W=4.
- Sub-module rr_arbiter:
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant, grant index.
  - Pure combinational; fixed-priority mode selected by the macro.
- The top instantiates the existing ALU once, plus rr_arbiter.

Test Plan:
1. Single op: requester 0 sends a=7, b=5, op=SUB with rsp_ready=1. Expect rsp_valid[0] next cycle, result=2, is_true=1; state returns to IDLE.
2. Contention: both valid at once with rr_ptr=0. Requester 0 gets a=3, b=3, op=EQ, result=1. Requester 1 gets a=-4, b=2, op=LT, result=1, and is granted the cycle after; rr_ptr ends at 0.
3. Backpressure: owner 1 holds rsp_ready=0 for 5 cycles with req_valid[0]=1. Expect req_ready=0, rsp_result stable at SRA(0x80000000, 4)=0xF8000000. Requester 0 is granted in the cycle rsp_ready[1] rises.
4. Back-to-back: requester 0 sends 4 ADDs with rsp_ready=1 throughout. Expect 4 responses in 4 consecutive cycles; results 1+1=2, 2+2=4, 3+3=6, 4+4=8.
5. Reset mid-op: rst_n low for 1 cycle while in RESP. Expect rsp_valid=0, rsp_result=0 and busy=0 immediately (async); the next grant goes to index 0.
6. Fixed priority with macro defined: both requesters valid for 4 cycles. Expect all 4 grants to index 0 and none to index 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU and the ALU arbiter.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        AND = 4'd2,
        OR  = 4'd3,
        XOR = 4'd4,
        SLL = 4'd5,
        SRL = 4'd6,
        SRA = 4'd7,
        EQ  = 4'd8,
        NE  = 4'd9,
        LT  = 4'd10,
        GE  = 4'd11
    } alu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: arithmetic, logic, shift and signed compare ops.
// is_true is high whenever the result is non-zero; undefined op codes yield 0.
module alu
    import alu_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [ALU_OP_W-1:0]  alu_control,
    output logic [DATAWIDTH-1:0] result,
    output logic                 is_true
);

    localparam int SHW = $clog2(DATAWIDTH);

    logic [SHW-1:0] shamt;

    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        case (alu_control)
            ADD:     result = a + b;
            SUB:     result = a - b;
            AND:     result = a & b;
            OR:      result = a | b;
            XOR:     result = a ^ b;
            SLL:     result = a << shamt;
            SRL:     result = a >> shamt;
            SRA:     result = DATAWIDTH'($signed(a) >>> shamt);
            EQ:      result = DATAWIDTH'(a == b);
            NE:      result = DATAWIDTH'(a != b);
            LT:      result = DATAWIDTH'($signed(a) < $signed(b));
            GE:      result = DATAWIDTH'($signed(a) >= $signed(b));
            default: result = '0;
        endcase
    end

    assign is_true = |result;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; ALU_ARB_FIXED_PRIO_EN selects fixed
// priority (lowest index wins, ptr ignored).
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     gnt_idx
);

    int unsigned    idx;
    logic [IDW-1:0] sel;
    logic           found;

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            idx = i;
`else
            // search starts at ptr and wraps modulo NUM_REQ
            idx = i + 32'(ptr);
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
`endif
            sel = IDW'(idx);
            if (en && !found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                gnt_idx    = sel;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ valid/ready requesters with a registered,
// held response. Define ALU_ARB_FIXED_PRIO_EN for fixed-priority arbitration.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int NUM_REQ   = 2,
    parameter int IDW       = $clog2(NUM_REQ)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0][DATAWIDTH-1:0]  req_a,
    input  logic [NUM_REQ-1:0][DATAWIDTH-1:0]  req_b,
    input  logic [NUM_REQ-1:0][ALU_OP_W-1:0]   req_op,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    input  logic [NUM_REQ-1:0]                 rsp_ready,
    output logic [DATAWIDTH-1:0]               rsp_result,
    output logic                               rsp_is_true,
    output logic                               busy
);

    arb_state_t           state, state_d;
    logic [IDW-1:0]       owner;
    logic [IDW-1:0]       arb_ptr;
    logic [IDW-1:0]       gnt_idx;
    logic [NUM_REQ-1:0]   grant;
    logic                 slot_open;
    logic                 xfer;
    logic [DATAWIDTH-1:0] alu_result;
    logic                 alu_is_true;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign arb_ptr = '0;
`else
    logic [IDW-1:0] rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign arb_ptr = rr_ptr;
`endif

    // rst_n gates the slot so no grant is visible while reset is held
    assign slot_open = rst_n && ((state == IDLE) || rsp_ready[owner]);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (arb_ptr),
        .en      (slot_open),
        .grant   (grant),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = grant;
    assign xfer      = |grant;

    alu #(
        .DATAWIDTH (DATAWIDTH)
    ) u_alu (
        .a           (req_a[gnt_idx]),
        .b           (req_b[gnt_idx]),
        .alu_control (req_op[gnt_idx]),
        .result      (alu_result),
        .is_true     (alu_is_true)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        if (xfer) begin
            state_d = RESP;
        end else if ((state == RESP) && rsp_ready[owner]) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner       <= '0;
            rsp_result  <= '0;
            rsp_is_true <= 1'b0;
        end else if (xfer) begin
            owner       <= gnt_idx;
            rsp_result  <= alu_result;
            rsp_is_true <= alu_is_true;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state == RESP) rsp_valid[owner] = 1'b1;
    end

    assign busy = (state == RESP);

endmodule
